uart_tx_core: RTL and testbench
===============================

# uart_tx_core

Serial transmitter for the UART link. It accepts a one-cycle start pulse with an 8-bit byte from the character-sequencing stage and shifts the byte out on `tx` as one 8N1 frame. It reports frame occupancy on `tx_done`, which the sequencer uses for its handshake. The block sits directly downstream of the sequencer and drives the board's UART TX pin.

## Interface
- `CLK_FREQ`, 100_000_000: clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `DIV` (derived, not overridable), `CLK_FREQ/BAUD` with integer truncation: clock cycles per bit. The default is 10416.

- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `btn_start`  in  1: start request. It is sampled only in IDLE, and one cycle high is sufficient.
- `tx_data_in`  in  8: byte to send. It is captured on the edge that accepts `btn_start`.
- `tx`  out  1: serial line, registered. It idles high.
- `tx_done`  out  1: frame-in-progress flag, registered. It is high from the first cycle of the start bit through the last cycle of the stop bit, and low in IDLE.

## Operation
- States:
  - IDLE: `tx`=1, `tx_done`=0.
  - START: `tx`=0.
  - DATA: `tx`=current bit.
  - STOP: `tx`=1.
- Internal registers:
  - `div_cnt`: width `$clog2(DIV)`, counts 0..DIV-1.
  - `bit_idx`: 3 bits.
  - `shift`: 8-bit copy of the byte being sent.
- IDLE -> START occurs when `btn_start`=1.
  - On that edge, `shift` <= `tx_data_in`, `div_cnt` <= 0 and `bit_idx` <= 0.
- Bit period:
  - `div_cnt` increments every cycle outside IDLE.
  - When `div_cnt`==DIV-1, it wraps to 0 and the state advances.
- START -> DATA at the end of the start bit.
- DATA sends `shift[bit_idx]`, LSB first.
  - At the end of each bit, `bit_idx` increments.
  - DATA -> STOP when `bit_idx`==7 at the end of a bit. `bit_idx` then wraps to 0.
- STOP -> IDLE at the end of the stop bit.
- `btn_start` is ignored outside IDLE. Requests are not queued, and `tx_data_in` changes during a frame have no effect.
- `tx` and `tx_done` are driven from registers decoded from the next-state value, so they have no combinational path from the inputs.
- Reset:
  - `tx`=1, `tx_done`=0, state=IDLE, `div_cnt`=0, `bit_idx`=0, `shift`=8'h00.
  - Reset takes effect on the next edge, including mid-frame: the line returns high immediately at that edge and the partial frame is abandoned.
  - `rst` has priority over `btn_start` on the same edge.

## Timing
- Edge E is the edge on which `btn_start`=1 is sampled in IDLE.
- From E+1, `tx`=0 and `tx_done`=1, i.e. zero dead cycles before the start bit.
- Start bit covers cycles E+1 .. E+DIV.
- Data bit k covers E+1+(k+1)·DIV .. E+(k+2)·DIV.
- Stop bit covers E+1+9·DIV .. E+10·DIV.
- At E+10·DIV+1: `tx_done`=0, `tx`=1, state=IDLE.
- A frame is exactly 10·DIV cycles with `tx_done` high.
- Back-to-back frames:
  - `btn_start` high in the first IDLE cycle (E+10·DIV+1) is accepted.
  - `tx_done` is therefore low for a minimum of 1 cycle between frames.
  - The gap is idle-high for exactly that 1 cycle. The sequencer's pulse-on-low handshake yields this minimal gap.
- `btn_start` held high continuously produces continuous frames separated by 1-cycle gaps, and each frame latches `tx_data_in` afresh.
- No baud tick is shared with other blocks. Bit timing is re-phased at each accepted start.

## Test plan
Test-plan parameters are CLK_FREQ=1000 and BAUD=100, so DIV=10.

1. Single byte:
   - Stimulus: reset 2 cycles, then a one-cycle `btn_start` with `tx_data_in`=8'h30.
   - Required `tx` sampled mid-bit (cycles E+5+10k, k=0..9): 0,0,0,0,0,1,1,0,0,1.
   - Required `tx_done`: high for exactly 100 cycles starting at E+1.
2. Ignored request:
   - Stimulus: send 8'h41, pulse `btn_start` with 8'hFF at E+37.
   - Required: frame bits remain 8'h41 (LSB first 1,0,0,0,0,0,1,0) and no second frame starts after E+100.
3. Back-to-back:
   - Stimulus: hold `btn_start`=1 with data 8'h55, then 8'hAA.
   - Required: first frame ends at E+100 and `tx_done` is low only at E+101.
   - Required: second start bit begins at E+102 and carries 8'hAA.
4. Reset mid-frame:
   - Stimulus: assert `rst` at E+45 during data bit 3.
   - Required: at E+46, `tx`=1 and `tx_done`=0.
   - Required: a new `btn_start` after release produces a clean full 100-cycle frame.
5. Reset/start collision:
   - Stimulus: `rst`=1 and `btn_start`=1 on the same edge.
   - Required: the block stays IDLE, `tx`=1, `tx_done`=0.
6. Edge bytes:
   - Stimulus: send 8'h00 then 8'hFF.
   - Required: 8'h00 gives `tx` low for 90 consecutive cycles and then high for the stop bit.
   - Required: 8'hFF gives `tx` low only for the 10-cycle start bit.

Source files
------------

// File: rtl/uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_core
// Description : 8N1 UART transmitter with a one-cycle start pulse and
//               registered line and frame-busy outputs.
// Revision    : 1.0
// ============================================================================
module uart_tx_core #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic [7:0] tx_data_in,
    output logic       tx,
    output logic       tx_done
);

    localparam int DIV = CLK_FREQ / BAUD;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] c_DIV_LAST = CW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_div_cnt;
    logic [CW-1:0] w_div_cnt_nxt;
    logic [2:0]    r_bit_idx;
    logic [2:0]    w_bit_idx_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic          r_tx;
    logic          r_tx_done;
    logic          w_tx_nxt;
    logic          w_tx_done_nxt;
    logic          w_bit_end;

    always_comb begin
        w_state_nxt   = r_state;
        w_div_cnt_nxt = r_div_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_bit_end     = (r_div_cnt == c_DIV_LAST);

        if (r_state == S_IDLE) begin
            if (btn_start) begin
                w_state_nxt   = S_START;
                w_shift_nxt   = tx_data_in;
                w_div_cnt_nxt = '0;
                w_bit_idx_nxt = '0;
            end
        end else begin
            w_div_cnt_nxt = w_bit_end ? '0 : (r_div_cnt + CW'(1));
        end

        case (r_state)
            S_START: begin
                if (w_bit_end) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    // 3-bit index wraps 7 -> 0 as the frame leaves DATA
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: ;
        endcase
    end

    // Outputs are decoded from the upcoming state so the registers hold the
    // value for the cycle that state occupies.
    always_comb begin
        w_tx_nxt      = 1'b1;
        w_tx_done_nxt = (w_state_nxt != S_IDLE);
        case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[w_bit_idx_nxt];
            default: w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_div_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= 8'h00;
            r_tx      <= 1'b1;
            r_tx_done <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_tx      <= w_tx_nxt;
            r_tx_done <= w_tx_done_nxt;
        end
    end

    assign tx      = r_tx;
    assign tx_done = r_tx_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_core
// Description : Self-checking bench for uart_tx_core (DIV = 10).
// Revision    : 1.0
// ============================================================================
module tb_uart_tx_core;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int FRAME    = 10 * DIV;

    logic       clk;
    logic       rst;
    logic       btn_start;
    logic [7:0] tx_data_in;
    logic       tx;
    logic       tx_done;

    int nvec;
    int nerr;
    int cur;

    uart_tx_core #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_start  (btn_start),
        .tx_data_in (tx_data_in),
        .tx         (tx),
        .tx_done    (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frame-level model: a frame is the 10-bit word {stop, data, start}
    // where each bit lasts DIV cycles, counted from the accepting edge.
    bit       m_armed = 1'b0;
    bit       m_busy  = 1'b0;
    int       m_t     = 0;
    bit [9:0] m_frame = '1;

    always @(posedge clk) begin
        if (rst) begin
            m_armed = 1'b1;
            m_busy  = 1'b0;
            m_t     = 0;
        end else if (m_busy) begin
            m_t = m_t + 1;
            if (m_t == FRAME) m_busy = 1'b0;
        end else if (btn_start) begin
            m_busy  = 1'b1;
            m_t     = 0;
            m_frame = {1'b1, tx_data_in, 1'b0};
        end
    end

    task automatic chk(input string name, input logic act, input logic exp);
        nvec = nvec + 1;
        if (act !== exp) begin
            nerr = nerr + 1;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_armed) begin
            chk("model_tx", tx, m_busy ? m_frame[m_t / DIV] : 1'b1);
            chk("model_tx_done", tx_done, m_busy);
        end
    end

    // Cycle E+n lies between edge E+n-1 and edge E+n; sample mid-cycle.
    task automatic goto(input int n);
        repeat (n - cur) @(posedge clk);
        cur = n;
        @(negedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [7:0] d, input bit hold);
        @(negedge clk);
        #1;
        tx_data_in = d;
        btn_start  = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) btn_start = 1'b0;
        cur = 1;
    endtask

    task automatic wait_idle();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_done === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            nvec = nvec + 1;
            nerr = nerr + 1;
            $display("FAIL idle_timeout: tx_done=%b expected 0 within 300 cycles", tx_done);
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        logic [9:0] exp_bits;
        logic [7:0] aa;
        nvec       = 0;
        nerr       = 0;
        cur        = 0;
        rst        = 1'b1;
        btn_start  = 1'b0;
        tx_data_in = 8'h00;

        @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_tx", tx, 1'b1);
        chk("reset_tx_done", tx_done, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 1: single byte 8'h30
        exp_bits = 10'b1001100000;
        start_frame(8'h30, 1'b0);
        goto(1);
        chk("t1_done_first", tx_done, 1'b1);
        for (int k = 0; k < 10; k++) begin
            goto(5 + 10 * k);
            chk("t1_bit", tx, exp_bits[k]);
        end
        goto(100);
        chk("t1_done_last", tx_done, 1'b1);
        goto(101);
        chk("t1_done_end", tx_done, 1'b0);
        wait_idle();

        // 2: request during frame is ignored
        exp_bits = 10'b1010000010;
        start_frame(8'h41, 1'b0);
        for (int k = 0; k < 10; k++) begin
            if (k == 4) begin
                goto(37);
                tx_data_in = 8'hFF;
                btn_start  = 1'b1;
                goto(38);
                btn_start  = 1'b0;
            end
            goto(5 + 10 * k);
            chk("t2_bit", tx, exp_bits[k]);
        end
        goto(105);
        chk("t2_no_refire", tx_done, 1'b0);
        goto(120);
        chk("t2_still_idle", tx, 1'b1);
        wait_idle();

        // 3: back-to-back frames with start held high
        start_frame(8'h55, 1'b1);
        goto(15);
        chk("t3_first_bit0", tx, 1'b1);
        goto(50);
        tx_data_in = 8'hAA;
        goto(100);
        chk("t3_done_e100", tx_done, 1'b1);
        goto(101);
        chk("t3_gap_done", tx_done, 1'b0);
        chk("t3_gap_tx", tx, 1'b1);
        goto(102);
        chk("t3_restart_done", tx_done, 1'b1);
        chk("t3_restart_tx", tx, 1'b0);
        btn_start = 1'b0;
        aa = 8'hAA;
        for (int k = 0; k < 8; k++) begin
            goto(116 + 10 * k);
            chk("t3_second_bit", tx, aa[k]);
        end
        wait_idle();

        // 4: reset mid-frame
        start_frame(8'h5A, 1'b0);
        goto(45);
        rst = 1'b1;
        goto(46);
        chk("t4_rst_tx", tx, 1'b1);
        chk("t4_rst_done", tx_done, 1'b0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        start_frame(8'hC3, 1'b0);
        goto(1);
        chk("t4_new_first", tx_done, 1'b1);
        goto(100);
        chk("t4_new_last", tx_done, 1'b1);
        goto(101);
        chk("t4_new_end", tx_done, 1'b0);
        wait_idle();

        // 5: reset and start on the same edge
        @(negedge clk);
        #1;
        rst        = 1'b1;
        btn_start  = 1'b1;
        tx_data_in = 8'h77;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("t5_tx", tx, 1'b1);
        chk("t5_done", tx_done, 1'b0);
        rst       = 1'b0;
        btn_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("t5_stays_idle", tx_done, 1'b0);
        repeat (2) @(posedge clk);

        // 6: edge bytes
        start_frame(8'h00, 1'b0);
        for (int n = 1; n <= FRAME; n++) begin
            goto(n);
            chk("t6_zero", tx, (n <= 90) ? 1'b0 : 1'b1);
        end
        wait_idle();
        start_frame(8'hFF, 1'b0);
        for (int n = 1; n <= FRAME; n++) begin
            goto(n);
            chk("t6_ones", tx, (n <= 10) ? 1'b0 : 1'b1);
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
`default_nettype wire
